// File: rtl/ila_dump_ctrl.sv
// ILA sample buffer readout sequencer: walks index/word select,
// hides the buffer read latency and streams words over valid/ready.
module ila_dump_ctrl #(
  parameter int DATA_W   = 32,
  parameter int BUFFER_W = 10,
  parameter int WORDS    = 2,
  parameter int SEL_W    = 1,
  parameter int READ_LAT = 2
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                circular_i,
  input  logic [BUFFER_W-1:0] samples_i,
  output logic [BUFFER_W-1:0] index_o,
  output logic [SEL_W-1:0]    value_select_o,
  input  logic [DATA_W-1:0]   value_i,
  output logic                m_valid_o,
  output logic [DATA_W-1:0]   m_data_o,
  output logic                m_last_o,
  input  logic                m_ready_i,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CNT_W = BUFFER_W + 1;
  localparam int WT_W  = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_e;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t             DEPTH    = cnt_t'(1) << BUFFER_W;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WORDS - 1);
  localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(READ_LAT);

  state_e              state_q, state_d;
  logic [BUFFER_W-1:0] index_q, index_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  cnt_t                scnt_q, scnt_d;
  cnt_t                total_q, total_d;
  logic [WT_W-1:0]     wcnt_q, wcnt_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;

  logic [BUFFER_W-1:0] first_idx;
  cnt_t                first_tot;

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    sel_d     = sel_q;
    scnt_d    = scnt_q;
    total_d   = total_q;
    wcnt_d    = wcnt_q;
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    first_idx = circular_i ? samples_i : '0;
    first_tot = circular_i ? DEPTH : {1'b0, samples_i};

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          total_d = first_tot;
          if (first_tot == '0) begin
            state_d = S_DONE;
          end else begin
            index_d = first_idx;
            sel_d   = '0;
            scnt_d  = '0;
            wcnt_d  = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == WT_LAST) begin
          data_d  = value_i;
          valid_d = 1'b1;
          last_d  = (scnt_q == total_q - cnt_t'(1)) &&
                    (sel_q == SEL_LAST);
          state_d = S_PRESENT;
        end else begin
          wcnt_d = wcnt_q + WT_W'(1);
        end
      end
      S_PRESENT: begin
        if (m_ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            // word select is the fast index, sample address the slow one
            if (sel_q != SEL_LAST) begin
              sel_d = sel_q + SEL_W'(1);
            end else begin
              sel_d   = '0;
              scnt_d  = scnt_q + cnt_t'(1);
              index_d = index_q + BUFFER_W'(1);
            end
            wcnt_d  = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      index_d = '0;
      sel_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= S_IDLE;
      index_q <= '0;
      sel_q   <= '0;
      scnt_q  <= '0;
      total_q <= '0;
      wcnt_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      index_q <= index_d;
      sel_q   <= sel_d;
      scnt_q  <= scnt_d;
      total_q <= total_d;
      wcnt_q  <= wcnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign index_o        = index_q;
  assign value_select_o = sel_q;
  assign m_valid_o      = valid_q;
  assign m_data_o       = data_q;
  assign m_last_o       = last_q;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);

endmodule

// File: tb/tb_ila_dump_ctrl.sv
// Directed bench for ila_dump_ctrl: linear/circular dumps, backpressure,
// abort, reset and clock-enable behaviour against latency-modelled RAMs.
module tb_ila_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic        a_cke = 1'b1, a_start = 1'b0, a_abort = 1'b0;
  logic        a_circ = 1'b0, a_ready = 1'b0;
  logic [9:0]  a_samples = '0;
  logic [9:0]  a_index;
  logic [0:0]  a_sel;
  logic [31:0] a_value, a_data;
  logic        a_valid, a_last, a_busy, a_done;
  logic [31:0] a_p1 = '0, a_p2 = '0;

  logic        b_cke = 1'b1, b_start = 1'b0, b_abort = 1'b0;
  logic        b_circ = 1'b0, b_ready = 1'b0;
  logic [2:0]  b_samples = '0;
  logic [2:0]  b_index;
  logic [0:0]  b_sel;
  logic [31:0] b_value, b_data;
  logic        b_valid, b_last, b_busy, b_done;
  logic [31:0] b_p1 = '0, b_p2 = '0;

  function automatic logic [31:0] ram_a(logic [9:0] i, logic [0:0] s);
    return 32'hA500_0000 | (32'(i) << 4) | 32'(s);
  endfunction

  function automatic logic [31:0] ram_b(logic [2:0] i);
    return 32'hC0DE_0000 | (32'(i) * 32'h111);
  endfunction

  // two-stage read pipeline models READ_LAT=2
  always @(posedge clk) begin
    a_p1 <= ram_a(a_index, a_sel);
    a_p2 <= a_p1;
    b_p1 <= ram_b(b_index);
    b_p2 <= b_p1;
  end
  assign a_value = a_p2;
  assign b_value = b_p2;

  ila_dump_ctrl #(
    .DATA_W(32), .BUFFER_W(10), .WORDS(2), .SEL_W(1), .READ_LAT(2)
  ) u_a (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(a_cke),
    .start_i(a_start), .abort_i(a_abort), .circular_i(a_circ),
    .samples_i(a_samples), .index_o(a_index),
    .value_select_o(a_sel), .value_i(a_value),
    .m_valid_o(a_valid), .m_data_o(a_data), .m_last_o(a_last),
    .m_ready_i(a_ready), .busy_o(a_busy), .done_o(a_done)
  );

  ila_dump_ctrl #(
    .DATA_W(32), .BUFFER_W(3), .WORDS(1), .SEL_W(1), .READ_LAT(2)
  ) u_b (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(b_cke),
    .start_i(b_start), .abort_i(b_abort), .circular_i(b_circ),
    .samples_i(b_samples), .index_o(b_index),
    .value_select_o(b_sel), .value_i(b_value),
    .m_valid_o(b_valid), .m_data_o(b_data), .m_last_o(b_last),
    .m_ready_i(b_ready), .busy_o(b_busy), .done_o(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input int n);
    a_circ    = 1'b0;
    a_samples = 10'(n);
    a_start   = 1'b1;
    tick();
    a_start   = 1'b0;
  endtask

  task automatic beat_a(input int idx, input int sel, input bit last);
    int w;
    w = 0;
    while (a_valid !== 1'b1 && w < 12) begin
      tick();
      w++;
    end
    chk("a_lat", 32'(w), 32'd3);
    chk("a_valid", 32'(a_valid), 32'd1);
    chk("a_index", 32'(a_index), 32'(idx));
    chk("a_sel", 32'(a_sel), 32'(sel));
    chk("a_data", a_data, ram_a(10'(idx), 1'(sel)));
    chk("a_last", 32'(a_last), 32'(last));
  endtask

  task automatic beats_a(input int from, input int n);
    for (int b = from; b < 2 * n; b++) begin
      beat_a(b / 2, b % 2, b == 2 * n - 1);
      tick();
      chk("a_valid_drop", 32'(a_valid), 32'd0);
      chk("a_done_edge", 32'(a_done), 32'(b == 2 * n - 1));
    end
    chk("a_busy_done", 32'(a_busy), 32'd1);
    tick();
    chk("a_done_clr", 32'(a_done), 32'd0);
    chk("a_busy_clr", 32'(a_busy), 32'd0);
  endtask

  initial begin
    int seen;
    repeat (3) tick();
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_index", 32'(a_index), 32'd0);
    chk("rst_a_data", a_data, 32'd0);
    chk("rst_b_done", 32'(b_done), 32'd0);
    rst_n   = 1'b1;
    a_ready = 1'b1;
    b_ready = 1'b1;
    tick();

    // linear, 3 samples x 2 words
    start_a(3);
    chk("s1_busy", 32'(a_busy), 32'd1);
    chk("s1_valid0", 32'(a_valid), 32'd0);
    beats_a(0, 3);

    // empty linear dump
    start_a(0);
    chk("s2_done", 32'(a_done), 32'd1);
    chk("s2_valid", 32'(a_valid), 32'd0);
    tick();
    chk("s2_done_clr", 32'(a_done), 32'd0);
    chk("s2_busy", 32'(a_busy), 32'd0);

    // circular, 8-deep, 1 word/sample, start at 5
    b_circ    = 1'b1;
    b_samples = 3'd5;
    b_start   = 1'b1;
    tick();
    b_start   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      int w;
      w = 0;
      while (b_valid !== 1'b1 && w < 12) begin
        tick();
        w++;
      end
      chk("s3_valid", 32'(b_valid), 32'd1);
      chk("s3_index", 32'(b_index), 32'((5 + k) % 8));
      chk("s3_sel", 32'(b_sel), 32'd0);
      chk("s3_data", b_data, ram_b(3'((5 + k) % 8)));
      chk("s3_last", 32'(b_last), 32'(k == 7));
      tick();
    end
    chk("s3_done", 32'(b_done), 32'd1);
    tick();
    chk("s3_busy", 32'(b_busy), 32'd0);

    // backpressure on beat 2, samples_i changed mid-dump
    start_a(3);
    beat_a(0, 0, 1'b0);
    tick();
    beat_a(0, 1, 1'b0);
    a_ready   = 1'b0;
    a_samples = 10'd7;
    repeat (10) begin
      tick();
      chk("s4_valid", 32'(a_valid), 32'd1);
      chk("s4_data", a_data, ram_a(10'd0, 1'd1));
      chk("s4_index", 32'(a_index), 32'd0);
    end
    a_ready = 1'b1;
    tick();
    chk("s4_drop", 32'(a_valid), 32'd0);
    beats_a(2, 3);

    // abort after beat 3, then full restart
    start_a(3);
    for (int b = 0; b < 3; b++) begin
      beat_a(b / 2, b % 2, 1'b0);
      tick();
    end
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("s5_busy", 32'(a_busy), 32'd0);
    chk("s5_valid", 32'(a_valid), 32'd0);
    chk("s5_done", 32'(a_done), 32'd0);
    chk("s5_index", 32'(a_index), 32'd0);
    chk("s5_sel", 32'(a_sel), 32'd0);
    seen = 0;
    repeat (8) begin
      tick();
      seen |= 32'(a_done) | 32'(a_busy);
    end
    chk("s5_quiet", 32'(seen), 32'd0);
    start_a(3);
    beats_a(0, 3);

    // abort together with start in IDLE: no dump
    a_samples = 10'd3;
    a_abort   = 1'b1;
    a_start   = 1'b1;
    tick();
    a_abort   = 1'b0;
    a_start   = 1'b0;
    chk("s5_abort_start", 32'(a_busy), 32'd0);

    // async reset mid-WAIT
    start_a(3);
    beat_a(0, 0, 1'b0);
    tick();
    beat_a(0, 1, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("s6_rst_busy", 32'(a_busy), 32'd0);
    chk("s6_rst_index", 32'(a_index), 32'd0);
    chk("s6_rst_data", a_data, 32'd0);
    chk("s6_rst_valid", 32'(a_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();

    // start held high through a dump is ignored
    a_samples = 10'd2;
    a_start   = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) begin
      beat_a(b / 2, b % 2, 1'b0);
      tick();
    end
    a_start = 1'b0;
    beats_a(3, 2);

    // clock enable low while presenting
    start_a(2);
    beat_a(0, 0, 1'b0);
    a_cke = 1'b0;
    repeat (5) begin
      tick();
      chk("s6_cke_valid", 32'(a_valid), 32'd1);
      chk("s6_cke_index", 32'(a_index), 32'd0);
      chk("s6_cke_sel", 32'(a_sel), 32'd0);
    end
    a_cke = 1'b1;
    tick();
    beats_a(1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
